// File: rtl/seg7_scan_driver_if.sv
// Load bus and display pins of the multi-digit 7-segment scan driver.
// The datapath side (master) supplies the value set; the driver (slave) owns seg/anode.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 2
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lz_suppress;
  logic                    load;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    dbg_state;

  // load is a single-cycle strobe with no back-pressure: the value set on
  // digits/blank/lz_suppress is taken on every rising edge where load=1.
  // dbg_state reports the scan FSM: 0 = dead-time gap, 1 = digit driven.
  modport master (
    output digits, blank, lz_suppress, load,
    input  seg, anode, dbg_state
  );

  modport slave (
    input  digits, blank, lz_suppress, load,
    output seg, anode, dbg_state
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with frame-boundary double
// buffering, per-slot dead time, per-digit blanking and leading-zero blanking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS       = 2,
  parameter int REFRESH_DIV      = 24000,
  parameter int DEAD_CYCLES      = 240,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic {S_DEAD = 1'b0, S_ON = 1'b1} state_t;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz;
  } set_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  set_t                  r_shadow, r_active, w_active_nxt, w_load_set;
  logic                  r_pending, w_pending_nxt;
  logic [6:0]            r_seg, w_seg_nxt;
  logic [NUM_DIGITS-1:0] r_anode, w_anode_nxt, w_onehot;
  logic                  w_wrap, w_boundary;
  logic [3:0]            w_nib;
  logic                  w_forced, w_suppress, w_zero_acc;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'b1000000;
      4'h1: font = 7'b1111001;
      4'h2: font = 7'b0100100;
      4'h3: font = 7'b0110000;
      4'h4: font = 7'b0011001;
      4'h5: font = 7'b0010010;
      4'h6: font = 7'b0000010;
      4'h7: font = 7'b1111000;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0010000;
      4'hA: font = 7'b0100000;
      4'hB: font = 7'b0000011;
      4'hC: font = 7'b1000110;
      4'hD: font = 7'b0100001;
      4'hE: font = 7'b0000100;
      default: font = 7'b0001110;
    endcase
  endfunction

  // Position of the cycle that the coming edge enters.
  always_comb begin
    w_wrap     = (r_cnt == CNT_MAX);
    w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
    w_idx_nxt  = r_idx;
    if (w_wrap) begin
      w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end
    w_boundary = w_wrap && (r_idx == IDX_MAX);
  end

  // A load coinciding with the frame boundary bypasses the shadow register.
  always_comb begin
    w_load_set    = {bus.digits, bus.blank, bus.lz_suppress};
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;
    if (w_boundary) begin
      w_pending_nxt = 1'b0;
      if (bus.load) begin
        w_active_nxt = w_load_set;
      end else if (r_pending) begin
        w_active_nxt = r_shadow;
      end
    end else if (bus.load) begin
      w_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_DEAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_ON;
    if ((DEAD_CYCLES > 0) && (w_cnt_nxt < DEAD_END)) begin
      w_state_nxt = S_DEAD;
    end
  end

  // Resolve the digit entering display; scanning from the top digit down
  // accumulates whether every nibble from i upward is zero.
  always_comb begin
    w_zero_acc  = 1'b1;
    w_nib       = 4'd0;
    w_forced    = 1'b0;
    w_suppress  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_acc = w_zero_acc & (w_active_nxt.digits[4*i +: 4] == 4'd0);
      if (w_idx_nxt == IDX_W'(i)) begin
        w_nib      = w_active_nxt.digits[4*i +: 4];
        w_forced   = w_active_nxt.blank[i];
        w_suppress = w_active_nxt.lz && w_zero_acc && (i != 0);
      end
    end
    w_onehot    = NUM_DIGITS'(1) << w_idx_nxt;
    w_seg_nxt   = 7'b1111111;
    w_anode_nxt = ANODE_OFF;
    if (w_state_nxt == S_ON) begin
      w_anode_nxt = (ANODE_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
      w_seg_nxt   = (w_forced || w_suppress) ? 7'b1111111 : font(w_nib);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
      r_seg     <= 7'b1111111;
      r_anode   <= ANODE_OFF;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_active  <= w_active_nxt;
      r_pending <= w_pending_nxt;
      r_seg     <= w_seg_nxt;
      r_anode   <= w_anode_nxt;
      if (bus.load) begin
        r_shadow <= w_load_set;
      end
    end
  end

  assign bus.seg       = r_seg;
  assign bus.anode     = r_anode;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: 4 digits, 8-cycle slots, 2 dead cycles, active-low anodes.
// Expected outputs come from a frame/slot model built on the recorded load history.
module tb_seg7_scan_driver;
  localparam int N     = 4;
  localparam int R     = 8;
  localparam int D     = 2;
  localparam int FRAME = N * R;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus();

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc;
  logic mon_en = 1'b0;

  int          ld_cyc[$];
  logic [15:0] ld_dig[$];
  logic [3:0]  ld_blk[$];
  logic        ld_lz[$];
  logic [10:0] exp_q[$];

  logic [6:0] font_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0100000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000100, 7'b0001110
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got=%0b expected=%0b", tag, cyc, got, exp);
    end
  endtask

  // Cycle index since reset release and the history of sampled loads.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0;
      ld_cyc.delete();
      ld_dig.delete();
      ld_blk.delete();
      ld_lz.delete();
    end else begin
      if (bus.load) begin
        ld_cyc.push_back(cyc);
        ld_dig.push_back(bus.digits);
        ld_blk.push_back(bus.blank);
        ld_lz.push_back(bus.lz_suppress);
      end
      cyc <= cyc + 1;
    end
  end

  // Frame F shows the last load sampled before its first cycle F*FRAME.
  function automatic logic [10:0] model_out(input int c);
    int pos, idx, frame;
    logic [15:0] dig;
    logic [3:0]  blk, nib, an;
    logic        lz;
    logic [6:0]  s;
    pos   = c % R;
    idx   = (c / R) % N;
    frame = c / FRAME;
    if (pos < D) return {4'b1111, 7'b1111111};
    dig = '0; blk = '0; lz = 1'b0;
    for (int k = 0; k < ld_cyc.size(); k++) begin
      if (ld_cyc[k] < frame * FRAME) begin
        dig = ld_dig[k]; blk = ld_blk[k]; lz = ld_lz[k];
      end
    end
    nib = 4'((dig >> (4 * idx)) & 16'hF);
    an  = ~(4'b0001 << idx);
    if (blk[idx]) s = 7'b1111111;
    else if (lz && idx > 0 && (dig >> (4 * idx)) == 16'd0) s = 7'b1111111;
    else s = font_tab[nib];
    return {an, s};
  endfunction

  task automatic step();
    @(negedge clk);
    if (mon_en && !reset) begin
      exp_q.push_back(model_out(cyc));
      check("scan", {bus.anode, bus.seg}, exp_q.pop_front());
      check("state_on", bus.dbg_state, ((cyc % R) >= D) ? 1 : 0);
    end
  endtask

  task automatic goto_cycle(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      step();
      guard++;
    end
    if (cyc != c) check("goto_timeout", cyc, c);
  endtask

  task automatic do_load(input int c, input logic [15:0] dig, input logic [3:0] blk, input logic lz);
    goto_cycle(c);
    bus.digits = dig; bus.blank = blk; bus.lz_suppress = lz; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic expect_at(input int c, input string tag, input logic [3:0] an, input logic [6:0] sg);
    goto_cycle(c);
    check(tag, {bus.anode, bus.seg}, {an, sg});
  endtask

  initial begin
    logic [15:0] rd;
    reset = 1'b1;
    bus.digits = '0; bus.blank = '0; bus.lz_suppress = 1'b0; bus.load = 1'b0;
    #2;
    check("rst_seg", bus.seg, 7'b1111111);
    check("rst_anode", bus.anode, 4'b1111);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    expect_at(1, "rst_dead", 4'b1111, 7'b1111111);
    expect_at(2, "rst_d0", 4'b1110, 7'b1000000);
    do_load(10, 16'h1A3F, 4'b0000, 1'b0);
    expect_at(32, "f1_dead", 4'b1111, 7'b1111111);
    expect_at(34, "f1_d0", 4'b1110, 7'b0001110);
    do_load(40, 16'h0050, 4'b0000, 1'b1);
    expect_at(43, "f1_d1", 4'b1101, 7'b0110000);
    expect_at(50, "f1_d2", 4'b1011, 7'b0100000);
    expect_at(58, "f1_d3", 4'b0111, 7'b1111001);
    expect_at(66, "lz_d0", 4'b1110, 7'b1000000);
    do_load(70, 16'h0000, 4'b0000, 1'b1);
    expect_at(74, "lz_d1", 4'b1101, 7'b0010010);
    expect_at(82, "lz_d2", 4'b1011, 7'b1111111);
    expect_at(90, "lz_d3", 4'b0111, 7'b1111111);
    expect_at(98, "lz0_d0", 4'b1110, 7'b1000000);
    expect_at(106, "lz0_d1", 4'b1101, 7'b1111111);
    do_load(106, 16'h2222, 4'b0000, 1'b0);
    expect_at(114, "db_old_d2", 4'b1011, 7'b1111111);
    expect_at(122, "db_old_d3", 4'b0111, 7'b1111111);
    expect_at(130, "db_new_d0", 4'b1110, 7'b0100100);
    expect_at(138, "db_new_d1", 4'b1101, 7'b0100100);
    do_load(159, 16'h4321, 4'b0000, 1'b0);
    do_load(160, 16'h9876, 4'b0000, 1'b0);
    expect_at(162, "pre_bnd_d0", 4'b1110, 7'b1111001);
    expect_at(170, "pre_bnd_d1", 4'b1101, 7'b0100100);
    expect_at(194, "on_bnd_d0", 4'b1110, 7'b0000010);
    do_load(200, 16'hABCD, 4'b0000, 1'b0);
    expect_at(202, "on_bnd_d1", 4'b1101, 7'b1111000);
    do_load(210, 16'hEF01, 4'b0000, 1'b0);
    expect_at(226, "two_ld_d0", 4'b1110, 7'b1111001);
    do_load(230, 16'h8888, 4'b0101, 1'b0);
    expect_at(234, "two_ld_d1", 4'b1101, 7'b1000000);
    expect_at(242, "two_ld_d2", 4'b1011, 7'b0001110);
    expect_at(250, "two_ld_d3", 4'b0111, 7'b0000100);
    expect_at(258, "blk_d0", 4'b1110, 7'b1111111);
    expect_at(266, "blk_d1", 4'b1101, 7'b0000000);
    expect_at(274, "blk_d2", 4'b1011, 7'b1111111);
    expect_at(282, "blk_d3", 4'b0111, 7'b0000000);

    for (int k = 0; k < 10; k++) begin
      rd = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rd = rd & 16'h000F;
        1: rd = rd & 16'h00FF;
        2: rd = rd & 16'h0F0F;
        default: ;
      endcase
      do_load(290 + k * 18 + $urandom_range(0, 5), rd,
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
              1'($urandom_range(0, 1)));
    end

    do_load(490, 16'h5555, 4'b0000, 1'b0);
    goto_cycle(500);
    check("mid_on_idx2", bus.anode, 4'b1011);
    #2 reset = 1'b1;
    #1;
    check("async_rst_seg", bus.seg, 7'b1111111);
    check("async_rst_anode", bus.anode, 4'b1111);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    expect_at(1, "rst2_dead", 4'b1111, 7'b1111111);
    expect_at(2, "rst2_d0", 4'b1110, 7'b1000000);
    expect_at(66, "rst2_drop_d0", 4'b1110, 7'b1000000);
    expect_at(74, "rst2_drop_d1", 4'b1101, 7'b1000000);
    goto_cycle(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode 7-segment digits, the multi-digit successor to the team's single-digit hex decoder. It latches a packed hex word plus blanking controls on a load strobe and scans one digit per refresh slot. Updates are double-buffered at frame boundaries, each slot starts with a dead-time gap to prevent ghosting, and leading zeros can optionally be suppressed. It sits between the datapath registers and the board's segment and anode pins.

## Interface
- NUM_DIGITS, 2: digits scanned, legal 1..8.
- REFRESH_DIV, 24000: clock cycles per digit slot; must be ≥ DEAD_CYCLES+1.
- DEAD_CYCLES, 240: leading cycles of each slot with all anodes off, legal ≥ 0.
- ANODE_ACTIVE_LOW, 1: 1 drives an enabled anode as 0; 0 drives it as 1.
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- digits  input  4*NUM_DIGITS  hex nibbles; nibble i is bits [4i+3:4i]; digit 0 is least significant and rightmost.
- blank  input  NUM_DIGITS  per-digit force-blank mask, captured with load.
- lz_suppress  input  1  leading-zero suppression enable, captured with load.
- load  input  1  single-cycle strobe that captures digits, blank and lz_suppress.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- anode  output  NUM_DIGITS  digit enables, polarity set by ANODE_ACTIVE_LOW; at most one enabled at a time.

## Operation
- Font, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0100000, b=0000011
  - C=1000110, d=0100001, E=0000100, F=0001110
  - blank=1111111
- Storage:
  - Shadow register: {digits, blank, lz_suppress} plus a pending flag, written when load=1.
  - Active register: the value set actually being displayed.
  - Repeated loads before a frame boundary: last one wins.
- Scan FSM, two states per slot:
  - DEAD: DEAD_CYCLES cycles; all anodes disabled, seg=1111111. Skipped when DEAD_CYCLES=0.
  - ON: the remaining REFRESH_DIV−DEAD_CYCLES cycles; anode[idx] enabled, seg = font of the resolved digit idx.
- Slot counter counts 0..REFRESH_DIV−1 and wraps. On wrap, idx increments; idx wraps from NUM_DIGITS−1 to 0.
- Frame boundary is the start of the slot with idx=0. If pending is set there, active takes the shadow value and pending clears.
- Simultaneous load and boundary: the new load value is copied straight to active. Pending stays clear.
- Digit resolution, in priority order:
  - blank[i]=1 → blank.
  - Else if lz_suppress=1, i>0, and nibbles i..NUM_DIGITS−1 are all 0 → blank.
  - Else → font of nibble i.
  - Digit 0 is never zero-suppressed.
- NUM_DIGITS=1: every slot is a frame boundary. Suppression never applies.

## Timing
- Reset, asynchronous, effective immediately without a clock edge:
  - seg=1111111; all anodes disabled.
  - Slot counter=0, idx=0, state=DEAD.
  - Shadow and active registers=0; pending=0.
- Cycle numbering: cycle 0 is the first rising edge after reset deasserts.
- Slot s occupies cycles [s·R, s·R+R−1], where R=REFRESH_DIV and D=DEAD_CYCLES:
  - Cycles s·R .. s·R+D−1 are blank.
  - Cycles s·R+D .. s·R+R−1 drive digit s mod NUM_DIGITS.
- seg and anode change only at slot or dead-time edges and are glitch-free (registered outputs).
- Load latency: a load sampled in cycle c appears from the first frame whose first cycle is > c. It never takes effect mid-frame.
- Reset asserted mid-slot or mid-frame aborts the scan and discards any pending load.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, ANODE_ACTIVE_LOW=1.
- Reset: hold reset, no clock edges → seg=1111111, anode=1111. Release → cycles 0–1 blank, cycles 2–7 anode=1110 and seg=1000000.
- Load 16'h1A3F before frame 1, blank=0, lz=0. In frame 1:
  - digit0: anode=1110, seg=0001110.
  - digit1: anode=1101, seg=0110000.
  - digit2: anode=1011, seg=0100000.
  - digit3: anode=0111, seg=1111001.
  - Every slot shows 2 blank cycles first.
- Load 16'h0050 with lz=1 → digits 3 and 2 blank (anode still enabled), digit1=0010010, digit0=1000000. Then load 16'h0000 with lz=1 → only digit0 shows 1000000.
- Double-buffering:
  - Load 16'h2222 during slot idx=1 → remaining slots of the current frame still show the old value; 0100100 appears from the next idx=0 slot.
  - Load on the exact boundary cycle → takes effect in the following frame.
  - Two loads in one frame → only the second is displayed.
- blank=4'b0101 with 16'h8888 → digits 0 and 2 show 1111111; digits 1 and 3 show 0000000.
- Reset asserted asynchronously mid-ON of idx=2 → outputs go blank before the next edge. After release, the scan restarts at idx=0 showing digits 0.
